// File: rtl/spi_slave_fe_if.sv
// Pin/RAM-side signal bundle for the SPI slave front end.
// rx_valid is a one-cycle strobe with no backpressure; tx_valid is a one-cycle strobe sampled only while a read is pending.
interface spi_slave_fe_if #(
  parameter int WORD_W = 10
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              frame_err;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, frame_err
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, frame_err
  );
endinterface

// File: rtl/spi_slave_fe.sv
// SPI slave front end: deserialises 10-bit commands from MOSI and, for read-data
// opcodes, serialises the RAM's response byte onto MISO MSB first.
module spi_slave_fe #(
  parameter int WORD_W     = 10,
  parameter int RD_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  spi_slave_fe_if.slave    bus,
  output logic [2:0]       o_state
);

  localparam int CW = $clog2(WORD_W + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RECV    = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t              r_state,    w_state;
  logic [WORD_W-2:0]   r_shift,    w_shift;
  logic [CW-1:0]       r_bit_cnt,  w_bit_cnt;
  logic [TW-1:0]       r_wait_cnt, w_wait_cnt;
  logic [6:0]          r_tx_shift, w_tx_shift;
  logic [2:0]          r_send_cnt, w_send_cnt;
  logic                r_miso,     w_miso;
  logic [WORD_W-1:0]   r_rx_data,  w_rx_data;
  logic                r_rx_valid, w_rx_valid;
  logic                r_frame_err, w_frame_err;

  // Only the first WORD_W-1 bits need storage; the last bit goes straight into the word.
  logic [WORD_W-1:0]   w_word;
  logic [TW-1:0]       w_wait_inc;

  assign w_word     = {r_shift, bus.MOSI};
  assign w_wait_inc = r_wait_cnt + TW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_tx_shift  <= '0;
      r_send_cnt  <= '0;
      r_miso      <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_shift     <= w_shift;
      r_bit_cnt   <= w_bit_cnt;
      r_wait_cnt  <= w_wait_cnt;
      r_tx_shift  <= w_tx_shift;
      r_send_cnt  <= w_send_cnt;
      r_miso      <= w_miso;
      r_rx_data   <= w_rx_data;
      r_rx_valid  <= w_rx_valid;
      r_frame_err <= w_frame_err;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_shift     = r_shift;
    w_bit_cnt   = r_bit_cnt;
    w_wait_cnt  = r_wait_cnt;
    w_tx_shift  = r_tx_shift;
    w_send_cnt  = r_send_cnt;
    w_miso      = r_miso;
    w_rx_data   = r_rx_data;
    w_rx_valid  = 1'b0;
    w_frame_err = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!bus.SS_n) begin
          w_shift   = {{(WORD_W-2){1'b0}}, bus.MOSI};
          w_bit_cnt = CW'(1);
          w_state   = ST_RECV;
        end
      end

      ST_RECV: begin
        if (bus.SS_n) begin
          w_state     = ST_IDLE;
          w_miso      = 1'b0;
          w_frame_err = 1'b1;
        end else begin
          w_shift   = w_word[WORD_W-2:0];
          w_bit_cnt = r_bit_cnt + CW'(1);
          if (r_bit_cnt == CW'(WORD_W - 1)) begin
            w_rx_data  = w_word;
            w_rx_valid = 1'b1;
            w_wait_cnt = '0;
            w_state    = (w_word[WORD_W-1:WORD_W-2] == 2'b11) ? ST_WAIT_RD : ST_DONE;
          end
        end
      end

      ST_WAIT_RD: begin
        if (bus.SS_n) begin
          w_state     = ST_IDLE;
          w_miso      = 1'b0;
          w_frame_err = 1'b1;
        end else if (bus.tx_valid) begin
          w_tx_shift = bus.tx_data[6:0];
          w_miso     = bus.tx_data[7];
          w_send_cnt = '0;
          w_state    = ST_SEND;
        end else begin
          // Timeout fires on the edge where the counter reaches RD_TIMEOUT without a response.
          w_wait_cnt = w_wait_inc;
          if (w_wait_inc == TW'(RD_TIMEOUT)) begin
            w_frame_err = 1'b1;
            w_state     = ST_DONE;
          end
        end
      end

      ST_SEND: begin
        if (bus.SS_n) begin
          w_state     = ST_IDLE;
          w_miso      = 1'b0;
          w_frame_err = 1'b1;
        end else if (r_send_cnt == 3'd7) begin
          w_miso  = 1'b0;
          w_state = ST_DONE;
        end else begin
          w_miso     = r_tx_shift[6];
          w_tx_shift = {r_tx_shift[5:0], 1'b0};
          w_send_cnt = r_send_cnt + 3'd1;
        end
      end

      ST_DONE: begin
        if (bus.SS_n) w_state = ST_IDLE;
      end

      default: begin
        w_state = ST_IDLE;
        w_miso  = 1'b0;
      end
    endcase
  end

  assign bus.MISO      = r_miso;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign o_state       = r_state;

endmodule

// File: doc/spi_slave_fe.md
# spi_slave_fe

Serial front end that sits between the SPI pins and the single-port command RAM. It deserialises each SPI frame on MOSI into a 10-bit command word and presents it to the RAM with a one-cycle `rx_valid` strobe. For read-data commands (`rx_data[9:8] == 2'b11`) it waits for the RAM's `tx_valid`/`tx_data` response and shifts that byte out on MISO, MSB first.

## Interface
- `WORD_W`, 10: command word width; bits [9:8] are the opcode, bits [7:0] the payload.
- `RD_TIMEOUT`, 4: cycles to wait for `tx_valid` after a read-data command before aborting.
- `clk`  input  1  SPI/system clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `SS_n`  input  1  slave select, active low; frame boundary.
- `MOSI`  input  1  serial command data, MSB (bit 9) first.
- `MISO`  output  1  serial read data, MSB first; 0 when not sending.
- `rx_data`  output  10  assembled command word to the RAM.
- `rx_valid`  output  1  one-cycle strobe: `rx_data` is valid.
- `tx_data`  input  8  read byte from the RAM.
- `tx_valid`  input  1  `tx_data` is valid; sampled only in WAIT_RD.
- `frame_err`  output  1  one-cycle pulse on an aborted frame or a read timeout.

## Operation
- Reset (`rst` high at a rising edge) sets: state IDLE, `MISO` 0, `rx_data` 0, `rx_valid` 0, `frame_err` 0, shift register 0, all counters 0. Reset overrides every other input, including in mid-frame.
- State IDLE: `SS_n` low at an edge → capture `MOSI` as bit 9, set `bit_cnt` to 1, go to RECV.
- State RECV: each edge with `SS_n` low shifts `MOSI` into the LSB and increments `bit_cnt`.
  - On the edge that captures bit 0 (10th bit): `rx_data` gets the full word and `rx_valid` goes to 1.
  - If the opcode is 11, go to WAIT_RD; otherwise go to DONE.
- State WAIT_RD: the wait counter increments each cycle.
  - `tx_valid` high → latch `tx_data`, `MISO` gets `tx_data[7]`, go to SEND.
  - Counter reaches `RD_TIMEOUT` with no `tx_valid` → pulse `frame_err`, go to DONE.
- State SEND: `MISO` shifts out bits 6..0 on the following 7 edges. After bit 0 has been driven for one cycle, `MISO` returns to 0 and the state goes to DONE.
- State DONE: ignore `MOSI`. Go to IDLE when `SS_n` is high.
- `SS_n` high in RECV, WAIT_RD or SEND:
  - Abort: go to IDLE, `MISO` 0, pulse `frame_err`.
  - If the abort happens in RECV, no `rx_valid` is issued.
- `rx_valid` is high for exactly one cycle per completed 10-bit word and is never asserted outside that edge. `rx_data` holds its value until the next word completes.
- `tx_valid` is ignored in every state except WAIT_RD. Extra `MOSI` bits after the 10th are ignored until `SS_n` rises.

## Timing
- Edge E10 captures the 10th bit. `rx_valid` is high in cycle E10..E10+1 only.
- RAM contract: `tx_valid` arrives at the earliest at E10+1 (registered RAM). WAIT_RD is entered at E10, so a response on the next cycle is accepted.
- When `tx_valid` is sampled at edge T, `MISO` is bit 7 in cycle T..T+1, bit 6 in T+1..T+2, and so on, down to bit 0 in T+7..T+8. `MISO` is 0 from T+8.
- Minimum `SS_n` high time between frames: 1 cycle. A frame can start on the edge right after returning to IDLE.
- `frame_err`: one-cycle pulse registered on the abort or timeout edge. It never coincides with `rx_valid`.
- Wait counter: counts up from 0 on entry to WAIT_RD. A timeout fires when it equals `RD_TIMEOUT`. Width is `$clog2(RD_TIMEOUT+1)`.

## Test plan
- Write-address frame: `SS_n` low, bits 00_0010_1010 → `rx_data` = 0x02A, `rx_valid` high for one cycle after the 10th bit, `MISO` stays 0, DONE until `SS_n` rises.
- Read-data frame: bits 11_0000_0000; RAM model returns `tx_valid` with 0xA5 one cycle after `rx_valid` → `rx_data` = 0x300, then `MISO` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, then 0.
- Abort: raise `SS_n` after 6 bits → no `rx_valid`, one `frame_err` pulse, IDLE next cycle; the following full frame 01_1111_1111 gives `rx_data` = 0x1FF.
- Read timeout: opcode 11 with no `tx_valid` for 4 cycles → `frame_err` pulse, `MISO` stays 0, a late `tx_valid` is ignored.
- Reset mid-SEND: assert `rst` after 3 MISO bits → next cycle all outputs are 0 and the state is IDLE; a new frame works normally.
- Back-to-back: two write frames separated by one `SS_n`-high cycle → two `rx_valid` pulses with `rx_data` 0x0FF then 0x155.
